// File: rtl/seven_segment_manager.sv
`default_nettype none
// ============================================================================
// Module   : seven_segment_manager
// Brief    : AHB-Lite seven-segment display peripheral. Software writes digit
//            codes and CONTROL into staging registers, then COMMITs; the
//            staging set is copied to the active set at the next frame
//            boundary. A DRIVE/BLANK scan engine multiplexes four
//            common-anode digits.
// Options  : `define LEADING_ZERO_BLANK_EN blanks leading zeros on digits 3..1.
// Revision : 1.0 - initial release
// ============================================================================
module seven_segment_manager #(
  parameter int SCAN_CYCLES  = 80,
  parameter int BLANK_CYCLES = 4
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic        HSEL,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic [3:0]  nDigit,
  output logic [6:0]  nSegment,
  output logic        nDP
);

  localparam int MAX_CYCLES = (SCAN_CYCLES > BLANK_CYCLES) ? SCAN_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [2:0] ADDR_IDLE = 3'd7;

  typedef enum logic [0:0] {ST_DRIVE = 1'b0, ST_BLANK = 1'b1} state_t;

  logic             write_q, write_d;
  logic [2:0]       addr_q, addr_d;
  logic [3:0][3:0]  digit_stg_q, digit_stg_d;
  logic [7:0]       ctrl_stg_q, ctrl_stg_d;
  logic             pending_q, pending_d;
  logic [3:0][3:0]  digit_act_q, digit_act_d;
  logic [7:0]       ctrl_act_q, ctrl_act_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             frame_edge;
  logic [3:0]       blank_lz;
  logic [3:0]       dp_act;
  logic             unused_bits;

  // Bus signals that carry no information for this word-only slave
  assign unused_bits = &{1'b0, HSIZE, HADDR[31:5], HADDR[1:0], HWDATA[31:8]};
  assign HREADYOUT   = 1'b1;
  assign dp_act      = ctrl_act_q[7:4];

  function automatic logic [6:0] glyph(input logic [3:0] code);
    case (code)
      4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h3F;  4'hB: glyph = 7'h06;
      4'hC: glyph = 7'h2F;  4'hD: glyph = 7'h47;
      4'hE: glyph = 7'h09;  default: glyph = 7'h7F;
    endcase
  endfunction

  // Capture the address phase of a selected, active transfer
  always_comb begin
    write_d = 1'b0;
    addr_d  = ADDR_IDLE;
    if (HSEL && HREADY && (HTRANS != 2'b00)) begin
      write_d = HWRITE;
      addr_d  = HADDR[4:2];
    end
  end

  // Data-phase register writes and commit-to-active transfer at frame edge
  always_comb begin
    digit_stg_d = digit_stg_q;
    ctrl_stg_d  = ctrl_stg_q;
    digit_act_d = digit_act_q;
    ctrl_act_d  = ctrl_act_q;
    pending_d   = pending_q;
    // Transfer uses pre-write staging values, so it reads the _q copies
    if (frame_edge && pending_q) begin
      digit_act_d = digit_stg_q;
      ctrl_act_d  = ctrl_stg_q;
      pending_d   = 1'b0;
    end
    if (write_q) begin
      case (addr_q)
        3'd0, 3'd1, 3'd2, 3'd3: digit_stg_d[addr_q[1:0]] = HWDATA[3:0];
        3'd4: ctrl_stg_d = {HWDATA[7:4], 3'b000, HWDATA[0]};
        3'd5: if (HWDATA[0]) pending_d = 1'b1;  // set wins over boundary clear
        default: ;
      endcase
    end
  end

  // Scan engine: DRIVE one digit, then BLANK all, then advance digit index
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    idx_d      = idx_q;
    frame_edge = 1'b0;
    case (state_q)
      ST_DRIVE: if (cnt_q == SCAN_LAST) begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
      ST_BLANK: if (cnt_q == BLANK_LAST) begin
        state_d    = ST_DRIVE;
        cnt_d      = '0;
        idx_d      = idx_q + 2'd1;
        frame_edge = (idx_q == 2'd3);
      end
      default: begin
        state_d = ST_DRIVE;
        cnt_d   = '0;
      end
    endcase
  end

  // Leading-zero suppression mask for the upper three digits
  always_comb begin
    blank_lz = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
    begin : lz_scan
      logic hi_ok;
      hi_ok = 1'b1;
      for (int i = 3; i >= 1; i--) begin
        blank_lz[i] = hi_ok && (digit_act_q[i] == 4'h0);
        hi_ok       = hi_ok && ((digit_act_q[i] == 4'h0) || (digit_act_q[i] == 4'hF));
      end
    end
`endif
  end

  // Display drive; everything inactive while blanking or disabled
  always_comb begin
    nDigit   = 4'hF;
    nSegment = 7'h7F;
    nDP      = 1'b1;
    if ((state_q == ST_DRIVE) && ctrl_act_q[0]) begin
      nDigit   = ~(4'b0001 << idx_q);
      nSegment = blank_lz[idx_q] ? 7'h7F : glyph(digit_act_q[idx_q]);
      nDP      = ~dp_act[idx_q];
    end
  end

  // Read mux from the registered address; zero during write data phases
  always_comb begin
    HRDATA = '0;
    if (!write_q) begin
      case (addr_q)
        3'd0, 3'd1, 3'd2, 3'd3: HRDATA = {28'b0, digit_stg_q[addr_q[1:0]]};
        3'd4:    HRDATA = {24'b0, ctrl_stg_q};
        3'd5:    HRDATA = {31'b0, pending_q};
        default: HRDATA = '0;
      endcase
    end
  end

  // State registers
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      write_q     <= 1'b0;
      addr_q      <= ADDR_IDLE;
      digit_stg_q <= '0;
      ctrl_stg_q  <= '0;
      pending_q   <= 1'b0;
      digit_act_q <= '0;
      ctrl_act_q  <= '0;
      state_q     <= ST_DRIVE;
      cnt_q       <= '0;
      idx_q       <= 2'd0;
    end else begin
      write_q     <= write_d;
      addr_q      <= addr_d;
      digit_stg_q <= digit_stg_d;
      ctrl_stg_q  <= ctrl_stg_d;
      pending_q   <= pending_d;
      digit_act_q <= digit_act_d;
      ctrl_act_q  <= ctrl_act_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_manager.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_segment_manager
// Brief    : Directed self-checking bench for seven_segment_manager.
//            Honours `define LEADING_ZERO_BLANK_EN for the zero-blank case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_segment_manager;

  localparam int FRAME = 336;
  localparam int SLOT  = 84;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic [31:0] HADDR = '0;
  logic [31:0] HWDATA = '0;
  logic        HWRITE = 1'b0;
  logic        HREADY = 1'b1;
  logic        HSEL = 1'b0;
  logic [2:0]  HSIZE = 3'b010;
  logic [1:0]  HTRANS = 2'b00;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic [3:0]  nDigit;
  logic [6:0]  nSegment;
  logic        nDP;

  int cmp = 0;
  int errs = 0;
  int cyc;

  seven_segment_manager dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HWDATA(HWDATA),
    .HWRITE(HWRITE), .HREADY(HREADY), .HSEL(HSEL), .HSIZE(HSIZE),
    .HTRANS(HTRANS), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
    .nDigit(nDigit), .nSegment(nSegment), .nDP(nDP)
  );

  always #5 HCLK = ~HCLK;

  // Edges since reset release == position in the scan sequence
  always @(posedge HCLK or posedge HRESET)
    if (HRESET) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {27'b0, a, 2'b00};
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0; HWDATA = d;
    @(posedge HCLK); #1;
    HWDATA = '0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {27'b0, a, 2'b00};
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0;
    d = HRDATA;
  endtask

  task automatic wait_pos(input int p);
    int n;
    n = 0;
    @(negedge HCLK);
    while (((cyc % FRAME) != p) && (n < 2 * FRAME)) begin
      @(negedge HCLK);
      n++;
    end
    if (n >= 2 * FRAME) begin
      cmp++; errs++;
      $display("FAIL wait_pos timeout: got pos %0d, required %0d", cyc % FRAME, p);
    end
  endtask

  // Expects to be entered at the negedge sample of frame position 0
  task automatic check_frame(input logic [6:0] s3, input logic [6:0] s2,
                             input logic [6:0] s1, input logic [6:0] s0,
                             input logic [3:0] dp, input bit en, input string nm);
    logic [6:0]  segs [4];
    logic [11:0] exp_v;
    logic [3:0]  nd;
    int pos, idx, w;
    segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
    for (int k = 0; k < FRAME; k++) begin
      pos = cyc % FRAME; idx = pos / SLOT; w = pos % SLOT;
      exp_v = {4'hF, 7'h7F, 1'b1};
      if (en && (w < 80)) begin
        nd    = ~(4'b0001 << idx);
        exp_v = {nd, segs[idx], ~dp[idx]};
      end
      cmp++;
      if ({nDigit, nSegment, nDP} !== exp_v) begin
        errs++;
        $display("FAIL %s pos=%0d {nDigit,nSegment,nDP} got=%h required=%h",
                 nm, pos, {nDigit, nSegment, nDP}, exp_v);
      end
      @(negedge HCLK);
    end
  endtask

  task automatic test_reset;
    logic [31:0] r;
    #1;
    cmp++;
    if ({nDigit, nSegment, nDP, HREADYOUT} !== {4'hF, 7'h7F, 1'b1, 1'b1}) begin
      errs++;
      $display("FAIL reset_outputs got=%h required=%h", {nDigit, nSegment, nDP, HREADYOUT}, 13'h1FFF);
    end
    cmp++;
    if (HRDATA !== 32'h0) begin errs++; $display("FAIL reset_hrdata got=%h required=0", HRDATA); end
    @(posedge HCLK); #1; HRESET = 1'b0;
    @(negedge HCLK);
    check_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'h0, 1'b0, "reset_blank_f1");
    check_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'h0, 1'b0, "reset_blank_f2");
    bus_read(3'd5, r);
    cmp++;
    if (r !== 32'h0) begin errs++; $display("FAIL reset_commit_rd got=%h required=0", r); end
  endtask

  task automatic test_basic;
    logic [31:0] r;
    wait_pos(100);
    bus_write(3'd0, 32'h1);
    bus_write(3'd1, 32'h2);
    bus_write(3'd2, 32'h3);
    bus_write(3'd3, 32'h4);
    bus_write(3'd4, 32'h21);
    bus_write(3'd5, 32'h1);
    bus_read(3'd5, r);
    cmp++;
    if (r !== 32'h1) begin errs++; $display("FAIL basic_pending_rd got=%h required=1", r); end
    wait_pos(0);
    check_frame(7'h19, 7'h30, 7'h24, 7'h79, 4'b0010, 1'b1, "basic_frame");
    bus_read(3'd5, r);
    cmp++;
    if (r !== 32'h0) begin errs++; $display("FAIL basic_commit_rd got=%h required=0", r); end
    bus_read(3'd4, r);
    cmp++;
    if (r !== 32'h21) begin errs++; $display("FAIL basic_control_rd got=%h required=21", r); end
  endtask

  task automatic test_no_commit;
    logic [31:0] r;
    bus_write(3'd0, 32'h8);
    bus_read(3'd0, r);
    cmp++;
    if (r !== 32'h8) begin errs++; $display("FAIL nocommit_digit0_rd got=%h required=8", r); end
    wait_pos(0);
    for (int f = 0; f < 3; f++)
      check_frame(7'h19, 7'h30, 7'h24, 7'h79, 4'b0010, 1'b1, "nocommit_frame");
  endtask

  task automatic test_boundary_commit;
    logic [31:0] r;
    wait_pos(100);
    bus_write(3'd0, 32'h5);
    bus_write(3'd5, 32'h1);
    wait_pos(334);
    bus_write(3'd5, 32'h1);          // data phase lands on the frame edge
    bus_read(3'd5, r);
    cmp++;
    if (r !== 32'h1) begin errs++; $display("FAIL boundary_pending_kept got=%h required=1", r); end
    @(negedge HCLK);
    cmp++;
    if ({nDigit, nSegment, nDP} !== {4'hE, 7'h12, 1'b1}) begin
      errs++;
      $display("FAIL boundary_first_xfer got=%h required=%h", {nDigit, nSegment, nDP}, {4'hE, 7'h12, 1'b1});
    end
    bus_write(3'd0, 32'h6);
    bus_read(3'd5, r);
    cmp++;
    if (r !== 32'h1) begin errs++; $display("FAIL boundary_pending_mid got=%h required=1", r); end
    wait_pos(0);
    check_frame(7'h19, 7'h30, 7'h24, 7'h02, 4'b0010, 1'b1, "boundary_second_xfer");
    bus_read(3'd5, r);
    cmp++;
    if (r !== 32'h0) begin errs++; $display("FAIL boundary_pending_cleared got=%h required=0", r); end
  endtask

  task automatic test_leading_zero;
    wait_pos(100);
    bus_write(3'd0, 32'h5);
    bus_write(3'd1, 32'h0);
    bus_write(3'd2, 32'h0);
    bus_write(3'd3, 32'h0);
    bus_write(3'd4, 32'h01);
    bus_write(3'd5, 32'h1);
    wait_pos(0);
`ifdef LEADING_ZERO_BLANK_EN
    check_frame(7'h7F, 7'h7F, 7'h7F, 7'h12, 4'b0000, 1'b1, "lz_frame");
`else
    check_frame(7'h40, 7'h40, 7'h40, 7'h12, 4'b0000, 1'b1, "lz_frame");
`endif
  endtask

  task automatic test_reset_mid;
    logic [31:0] r;
    wait_pos(40);
    cmp++;
    if ({nDigit, nSegment} !== {4'hE, 7'h12}) begin
      errs++;
      $display("FAIL mid_pre_reset got=%h required=%h", {nDigit, nSegment}, {4'hE, 7'h12});
    end
    #1 HRESET = 1'b1;
    #1;
    cmp++;
    if ({nDigit, nSegment, nDP} !== {4'hF, 7'h7F, 1'b1}) begin
      errs++;
      $display("FAIL mid_async_reset got=%h required=%h", {nDigit, nSegment, nDP}, {4'hF, 7'h7F, 1'b1});
    end
    @(posedge HCLK); @(posedge HCLK); #1; HRESET = 1'b0;
    @(negedge HCLK);
    check_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'h0, 1'b0, "mid_blank_f1");
    check_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'h0, 1'b0, "mid_blank_f2");
    bus_read(3'd5, r);
    cmp++;
    if (r !== 32'h0) begin errs++; $display("FAIL mid_pending_lost got=%h required=0", r); end
    bus_read(3'd0, r);
    cmp++;
    if (r !== 32'h0) begin errs++; $display("FAIL mid_digit0_cleared got=%h required=0", r); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_commit();
    test_boundary_commit();
    test_leading_zero();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
`default_nettype wire
